// File: rtl/slc3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slc3_pkg
//  Description : Shared definitions for the operand-read / writeback unit.
//                Holds the FSM state encoding, the SR1MUX/DRMUX select
//                encodings, the R7 register index, the NZP reset value and
//                a sign-extension helper.
//  Revision    : 1.0  initial release
// ============================================================================
package slc3_pkg;

   // Operand-read / writeback controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

   // SR1MUX: which IR field names the first source register
   localparam logic C_SR1MUX_IR11_9 = 1'b0;
   localparam logic C_SR1MUX_IR8_6  = 1'b1;

   // DRMUX: which destination register the instruction targets
   localparam logic C_DRMUX_IR11_9  = 1'b0;
   localparam logic C_DRMUX_R7      = 1'b1;

   // Link register index (used by JSR/TRAP style instructions)
   localparam logic [2:0] C_R7_IDX    = 3'd7;

   // Condition codes come out of reset as "zero"
   localparam logic [2:0] C_NZP_RESET = 3'b010;

   // Sign-extend the 5-bit immediate field to a full data word
   function automatic logic [15:0] sext5(input logic [4:0] v);
      return {{11{v[4]}}, v};
   endfunction

endpackage : slc3_pkg
`default_nettype wire

// File: rtl/nzp_logic.sv
`default_nettype none
// ============================================================================
//  Module      : nzp_logic
//  Description : Condition-code generator. Classifies a 16-bit two's
//                complement word as negative, zero or positive and returns
//                a one-hot {N,Z,P} code.
//  Ports       : data_i [15:0]  word to classify
//                nzp_o  [2:0]   one-hot {N,Z,P}
//  Revision    : 1.0  initial release
// ============================================================================
module nzp_logic (
   input  logic [15:0] data_i,
   output logic [2:0]  nzp_o
);

   always_comb begin
      nzp_o = 3'b001;
      if (data_i[15]) begin
         nzp_o = 3'b100;
      end else if (data_i == 16'h0000) begin
         nzp_o = 3'b010;
      end
   end

endmodule : nzp_logic
`default_nettype wire

// File: rtl/operand_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module      : operand_wb_unit
//  Description : Operand-read and writeback controller sitting in front of an
//                external 8x16 register file. On issue it latches the
//                instruction, selects source/destination registers, reads
//                both operands (or the 5-bit immediate) and presents them to
//                the datapath with a valid/ready handshake. On writeback it
//                drives a one-cycle register-file write to the destination of
//                the most recent issue and optionally updates NZP.
//  Ports       : Clk, Reset_n                 clock / async active-low reset
//                IR, SR1MUX, DRMUX            instruction and register selects
//                Issue_Valid / Issue_Ready    operand-read request handshake
//                SR1, SR2, DR, LD_REG, D      register-file controls
//                SR1_OUT, SR2_OUT             register-file read data
//                OpA, OpB, Op_Valid/Op_Ready  operand handshake to datapath
//                WB_Valid/WB_Ready, WB_Data, WB_LDCC  writeback handshake
//                NZP, BEN                     condition codes, branch enable
//  Revision    : 1.0  initial release
// ============================================================================
module operand_wb_unit
   import slc3_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [15:0] IR,
   input  logic        SR1MUX,
   input  logic        DRMUX,
   input  logic        Issue_Valid,
   output logic        Issue_Ready,
   output logic [2:0]  SR1,
   output logic [2:0]  SR2,
   output logic [2:0]  DR,
   output logic        LD_REG,
   output logic [15:0] D,
   input  logic [15:0] SR1_OUT,
   input  logic [15:0] SR2_OUT,
   output logic [15:0] OpA,
   output logic [15:0] OpB,
   output logic        Op_Valid,
   input  logic        Op_Ready,
   input  logic        WB_Valid,
   input  logic [15:0] WB_Data,
   input  logic        WB_LDCC,
   output logic        WB_Ready,
   output logic [2:0]  NZP,
   output logic        BEN
);

   state_e      state_q, state_d;
   logic [15:0] ir_q,    ir_d;
   logic [2:0]  sr1_q,   sr1_d;
   logic [2:0]  dr_q,    dr_d;
   logic [15:0] data_q,  data_d;
   logic        ldcc_q,  ldcc_d;
   logic [15:0] opa_q,   opa_d;
   logic [15:0] opb_q,   opb_d;
   logic [2:0]  nzp_q,   nzp_d;
   logic        ben_q,   ben_d;

   logic [2:0]  w_nzp_new;
   logic        w_unused_ir;

   // Condition code of the word currently being written back
   nzp_logic u_nzp (
      .data_i (data_q),
      .nzp_o  (w_nzp_new)
   );

   // Opcode bits are decoded elsewhere, and SR1 is resolved from IR[8:6] at
   // issue time, so those latched bits have no consumer here.
   assign w_unused_ir = ^{ir_q[15:12], ir_q[8:6]};

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      sr1_d   = sr1_q;
      dr_d    = dr_q;
      data_d  = data_q;
      ldcc_d  = ldcc_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      nzp_d   = nzp_q;
      ben_d   = ben_q;

      unique case (state_q)
         ST_IDLE: begin
            // A pending writeback takes priority so a result is never
            // stalled behind a new operand read.
            if (WB_Valid) begin
               data_d  = WB_Data;
               ldcc_d  = WB_LDCC;
               state_d = ST_WRITE;
            end else if (Issue_Valid) begin
               ir_d    = IR;
               sr1_d   = (SR1MUX == C_SR1MUX_IR8_6) ? IR[8:6] : IR[11:9];
               dr_d    = (DRMUX == C_DRMUX_R7) ? C_R7_IDX : IR[11:9];
               state_d = ST_READ;
            end
         end

         ST_READ: begin
            // Register-file read data is combinational on SR1/SR2, which
            // already carry the latched selects during this cycle.
            opa_d   = SR1_OUT;
            opb_d   = ir_q[5] ? sext5(ir_q[4:0]) : SR2_OUT;
            ben_d   = |(ir_q[11:9] & nzp_q);
            state_d = ST_HOLD;
         end

         ST_HOLD: begin
            if (Op_Ready) begin
               state_d = ST_IDLE;
            end
         end

         ST_WRITE: begin
            // NZP changes on the same edge that commits the register write
            if (ldcc_q) begin
               nzp_d = w_nzp_new;
            end
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         ir_q    <= 16'h0000;
         sr1_q   <= 3'd0;
         dr_q    <= 3'd0;
         data_q  <= 16'h0000;
         ldcc_q  <= 1'b0;
         opa_q   <= 16'h0000;
         opb_q   <= 16'h0000;
         nzp_q   <= C_NZP_RESET;
         ben_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         sr1_q   <= sr1_d;
         dr_q    <= dr_d;
         data_q  <= data_d;
         ldcc_q  <= ldcc_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         nzp_q   <= nzp_d;
         ben_q   <= ben_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // LD_REG and Op_Valid depend on state only, so an async reset removes
   // them immediately and no input can reach them combinationally.
   assign LD_REG      = (state_q == ST_WRITE);
   assign Op_Valid    = (state_q == ST_HOLD);

   assign WB_Ready    = (state_q == ST_IDLE);
   assign Issue_Ready = (state_q == ST_IDLE) && !WB_Valid;

   assign SR1         = sr1_q;
   assign SR2         = ir_q[2:0];
   assign DR          = dr_q;
   assign D           = data_q;
   assign OpA         = opa_q;
   assign OpB         = opb_q;
   assign NZP         = nzp_q;
   assign BEN         = ben_q;

endmodule : operand_wb_unit
`default_nettype wire

// File: doc/operand_wb_unit.md
OPERAND_WB_UNIT -- requirements
Module: operand_wb_unit

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, rising-edge.
REQ-002 SHALL have: Reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: IR  in  16  instruction word, sampled on issue accept.
REQ-004 SHALL have: SR1MUX  in  1  0: SR1=IR[11:9], 1: SR1=IR[8:6], sampled on issue accept.
REQ-005 SHALL have: DRMUX  in  1  0: DR=IR[11:9], 1: DR=3'b111, sampled on issue accept.
REQ-006 SHALL have: Issue_Valid  in  1 / Issue_Ready  out  1  operand-read request handshake.
REQ-007 SHALL have: SR1, SR2, DR  out  3 each / LD_REG  out  1 / D  out  16  register-file controls.
REQ-008 SHALL have: SR1_OUT, SR2_OUT  in  16 each  register-file combinational read data.
REQ-009 SHALL have: OpA, OpB  out  16 / Op_Valid  out  1 / Op_Ready  in  1  operand handshake to datapath.
REQ-010 SHALL have: WB_Valid  in  1 / WB_Data  in  16 / WB_LDCC  in  1 / WB_Ready  out  1  writeback handshake.
REQ-011 SHALL have: NZP  out  3  condition codes; BEN  out  1  branch-enable.

Function
REQ-012 SHALL implement FSM states IDLE, READ, HOLD, WRITE.
REQ-013 IDLE: WB_Ready=1; Issue_Ready=1 only when WB_Valid=0.
REQ-014 IDLE with WB_Valid=1 SHALL latch WB_Data and WB_LDCC, go to WRITE; writeback wins over simultaneous issue.
REQ-015 IDLE with Issue_Valid=1, WB_Valid=0 SHALL latch IR, computed SR1 and DR, go to READ.
REQ-016 SR2 SHALL always equal latched IR[2:0]; SR1 and DR SHALL drive latched values in all states.
REQ-017 READ end-of-cycle SHALL capture OpA=SR1_OUT; OpB=IR[5] ? sign-extend(IR[4:0]) to 16 bits : SR2_OUT; go to HOLD.
REQ-018 READ end-of-cycle SHALL register BEN = OR of (latched IR[11:9] AND NZP).
REQ-019 HOLD SHALL assert Op_Valid; OpA/OpB SHALL stay stable until Op_Valid&Op_Ready, then go to IDLE.
REQ-020 Op_Valid SHALL first assert 2 cycles after the issue-accept edge.
REQ-021 WRITE SHALL assert LD_REG for exactly one cycle with D=latched data, DR=latched DR; then IDLE.
REQ-022 WRITE with latched LDCC=1 SHALL update NZP at the same edge: 100 if D[15]=1, 010 if D==0, else 001.
REQ-023 Writeback SHALL target DR of the most recent accepted issue; DR unchanged between issues.
REQ-024 LD_REG, Op_Valid SHALL be decoded from state only (no input-to-output combinational path).
REQ-025 Issue_Valid and WB_Valid SHALL be ignored outside IDLE; Issue_Ready=WB_Ready=0 outside IDLE.

Reset
REQ-026 Reset_n=0 SHALL asynchronously force: state IDLE, LD_REG=0, Op_Valid=0, OpA=OpB=0, NZP=3'b010, BEN=0, latched IR=0, DR=0, latched data=0.
REQ-027 Reset mid-WRITE SHALL deassert LD_REG immediately; no register write on the following edge.
REQ-028 Reset mid-HOLD SHALL drop Op_Valid immediately; pending operands discarded.

Structure
REQ-029 Shared package slc3_pkg SHALL hold the FSM state enum, SR1MUX/DRMUX encodings, R7 index constant, NZP reset constant.
REQ-030 Condition-code generation SHALL be a sub-module nzp_logic (16-bit in, 3-bit one-hot out).
REQ-031 Register file SHALL be instantiated outside this block.

Verification
REQ-032 Issue IR=16'h1283 (ADD R1,R2,R3), SR1MUX=1, R2=5, R3=7 -> SR1=2, SR2=3, Op_Valid 2 cycles later, OpA=5, OpB=7, DR=1.
REQ-033 Issue IR=16'h12BF (ADD R1,R2,#-1), R2=5 -> OpB=16'hFFFF, OpA=5.
REQ-034 After REQ-032 issue, WB_Valid with WB_Data=16'h8000, WB_LDCC=1 -> one-cycle LD_REG, DR=1, D=16'h8000, NZP=100; next read of R1 returns 16'h8000.
REQ-035 Issue_Valid and WB_Valid together in IDLE -> Issue_Ready=0, WRITE first, issue accepted on IDLE return.
REQ-036 NZP=001, issue IR=16'h0201 (BRp) -> BEN=1; NZP=010 -> BEN=0; DRMUX=1 -> DR=7.
REQ-037 Reset_n low during WRITE -> LD_REG low within same cycle, target register unchanged, all outputs at REQ-026 values.
